// File: rtl/mult_pkg.sv
// Shared definitions for the shift-and-add multiplier datapath.
//   mult_state_t  : controller state encoding (IDLE, RUN, DONE)
//   DEFAULT_WIDTH : default operand width in bits
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mult_state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/seq_multiplier.sv
// Sequential unsigned shift-and-add multiplier.
// A loaddata strobe captures dataA/dataB. The block then runs WIDTH add/shift
// steps and publishes the product with a one-cycle done pulse.
//
// Ports:
//   clk      : system clock, rising edge
//   reset    : asynchronous active-low reset
//   loaddata : load strobe, honoured in IDLE and DONE only
//   dataA    : unsigned multiplicand (WIDTH bits)
//   dataB    : unsigned multiplier (WIDTH bits)
//   product  : registered 2*WIDTH-bit result, held until the next result lands
//   busy     : high while in RUN
//   done     : one-cycle pulse while in DONE
//
// state | meaning
// IDLE  | waiting for loaddata
// RUN   | one add/shift step per edge, WIDTH steps in total
// DONE  | product valid for one cycle; loaddata here starts a back-to-back op
module seq_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 loaddata,
  input  logic [WIDTH-1:0]     dataA,
  input  logic [WIDTH-1:0]     dataB,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy,
  output logic                 done
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  mult_state_t          state, nxt_state;
  logic [2*WIDTH-1:0]   mcand, nxt_mcand;
  logic [WIDTH-1:0]     mplier, nxt_mplier;
  logic [2*WIDTH-1:0]   acc, nxt_acc;
  logic [CNT_W-1:0]     cnt, nxt_cnt;
  logic [2*WIDTH-1:0]   step_acc;
  logic                 product_en;

  always_comb begin
    nxt_state  = state;
    nxt_mcand  = mcand;
    nxt_mplier = mplier;
    nxt_acc    = acc;
    nxt_cnt    = cnt;
    product_en = 1'b0;
    // Accumulator value after the current step; the final step's result
    // goes straight into product so no extra cycle is spent.
    step_acc   = acc + (mplier[0] ? mcand : '0);

    case (state)
      IDLE: begin
        if (loaddata) begin
          nxt_mcand  = {{WIDTH{1'b0}}, dataA};
          nxt_mplier = dataB;
          nxt_acc    = '0;
          nxt_cnt    = '0;
          nxt_state  = RUN;
        end
      end
      RUN: begin
        nxt_acc    = step_acc;
        nxt_mcand  = mcand << 1;
        nxt_mplier = mplier >> 1;
        nxt_cnt    = cnt + 1'b1;
        if (cnt == LAST_STEP) begin
          product_en = 1'b1;
          nxt_state  = DONE;
        end
      end
      DONE: begin
        if (loaddata) begin
          nxt_mcand  = {{WIDTH{1'b0}}, dataA};
          nxt_mplier = dataB;
          nxt_acc    = '0;
          nxt_cnt    = '0;
          nxt_state  = RUN;
        end else begin
          nxt_state  = IDLE;
        end
      end
      default: begin
        nxt_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      cnt     <= '0;
      product <= '0;
    end else begin
      state  <= nxt_state;
      mcand  <= nxt_mcand;
      mplier <= nxt_mplier;
      acc    <= nxt_acc;
      cnt    <= nxt_cnt;
      if (product_en) begin
        product <= step_acc;
      end
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed and random self-checking bench for seq_multiplier (WIDTH=8).
// Inputs are driven just after the falling edge. Outputs are sampled on the
// falling edge, away from the active rising edge.
module tb_seq_multiplier;

  localparam int W = 8;

  logic           clk;
  logic           reset;
  logic           loaddata;
  logic [W-1:0]   dataA;
  logic [W-1:0]   dataB;
  logic [2*W-1:0] product;
  logic           busy;
  logic           done;

  int total;
  int bad;

  seq_multiplier #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .loaddata (loaddata),
    .dataA    (dataA),
    .dataB    (dataB),
    .product  (product),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Presents one load cycle; returns at the falling edge after the load edge.
  task automatic load_op(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    loaddata = 1'b1;
    dataA    = a;
    dataB    = b;
    @(negedge clk);
    loaddata = 1'b0;
    dataA    = '0;
    dataB    = '0;
  endtask

  // Counts falling edges until done is seen (bounded).
  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < 30) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset;
    reset    = 1'b0;
    loaddata = 1'b0;
    dataA    = '0;
    dataB    = '0;
    repeat (2) @(negedge clk);
    total++;
    if (product !== 16'd0 || busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: product=%0d busy=%b done=%b, want 0/0/0", product, busy, done);
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    load_op(8'd3, 8'd5);
    for (int i = 0; i < 8; i++) begin
      total++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        bad++;
        $display("FAIL basic_busy[%0d]: busy=%b done=%b, want 1/0", i, busy, done);
      end
      @(negedge clk);
    end
    total++;
    if (done !== 1'b1 || busy !== 1'b0 || product !== 16'd15) begin
      bad++;
      $display("FAIL basic_done: done=%b busy=%b product=%0d, want 1/0/15", done, busy, product);
    end
    @(negedge clk);
    total++;
    if (done !== 1'b0 || busy !== 1'b0 || product !== 16'd15) begin
      bad++;
      $display("FAIL basic_after: done=%b busy=%b product=%0d, want 0/0/15", done, busy, product);
    end
  endtask

  task automatic test_single(input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [2*W-1:0] expv, input string name);
    int lat;
    load_op(a, b);
    wait_done(lat);
    total++;
    if (lat !== 8) begin
      bad++;
      $display("FAIL %s_latency: got %0d, want 8", name, lat);
    end
    total++;
    if (product !== expv) begin
      bad++;
      $display("FAIL %s_product: got %0d, want %0d", name, product, expv);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int lat;
    int gap;
    @(negedge clk);
    loaddata = 1'b1;
    dataA    = 8'd7;
    dataB    = 8'd9;
    @(negedge clk);
    dataA    = 8'd12;
    dataB    = 8'd12;
    wait_done(lat);
    total++;
    if (lat !== 8 || product !== 16'd63) begin
      bad++;
      $display("FAIL b2b_first: lat=%0d product=%0d, want 8/63", lat, product);
    end
    gap = 0;
    @(negedge clk);
    gap++;
    while (!done && gap < 30) begin
      total++;
      if (product !== 16'd63 || busy !== 1'b1) begin
        bad++;
        $display("FAIL b2b_hold: product=%0d busy=%b, want 63/1", product, busy);
      end
      @(negedge clk);
      gap++;
    end
    loaddata = 1'b0;
    total++;
    if (gap !== 9 || product !== 16'd144) begin
      bad++;
      $display("FAIL b2b_second: gap=%0d product=%0d, want 9/144", gap, product);
    end
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL b2b_idle: busy=%b done=%b, want 0/0", busy, done);
    end
  endtask

  task automatic test_load_in_run;
    int lat;
    int extra;
    load_op(8'd10, 8'd10);
    @(negedge clk);
    loaddata = 1'b1;
    dataA    = 8'd1;
    dataB    = 8'd1;
    @(negedge clk);
    loaddata = 1'b0;
    wait_done(lat);
    total++;
    if (lat !== 6 || product !== 16'd100) begin
      bad++;
      $display("FAIL run_load_ignored: lat=%0d product=%0d, want 6/100", lat, product);
    end
    extra = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done || busy) extra++;
    end
    total++;
    if (extra !== 0) begin
      bad++;
      $display("FAIL run_no_extra: active cycles=%0d, want 0", extra);
    end
  endtask

  task automatic test_async_reset;
    int lat;
    load_op(8'd100, 8'd3);
    repeat (4) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    total++;
    if (product !== 16'd0 || busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: product=%0d busy=%b done=%b, want 0/0/0", product, busy, done);
    end
    @(negedge clk);
    reset = 1'b1;
    load_op(8'd6, 8'd7);
    wait_done(lat);
    total++;
    if (lat !== 8 || product !== 16'd42) begin
      bad++;
      $display("FAIL post_reset: lat=%0d product=%0d, want 8/42", lat, product);
    end
    @(negedge clk);
  endtask

  task automatic test_random;
    int lat;
    int errs;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] expv;
    errs = 0;
    for (int i = 0; i < 500; i++) begin
      a    = W'($urandom_range(0, 255));
      b    = W'($urandom_range(0, 255));
      expv = (2*W)'(a) * (2*W)'(b);
      load_op(a, b);
      wait_done(lat);
      total++;
      if (lat !== 8 || product !== expv) begin
        bad++;
        errs++;
        if (errs <= 10)
          $display("FAIL random[%0d] %0d*%0d: lat=%0d product=%0d, want 8/%0d",
                   i, a, b, lat, product, expv);
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_basic();
    test_single(8'd255, 8'd255, 16'hFE01, "max");
    test_single(8'd0, 8'd200, 16'd0, "zero_a");
    test_single(8'd200, 8'd0, 16'd0, "zero_b");
    test_back_to_back();
    test_load_in_run();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
